// File: rtl/pipe_exec_reg.sv
// -----------------------------------------------------------------------------
// pipe_exec_reg
//   Decode-to-execute pipeline register for the pipelined Y86-64 core.
//   Each rising edge the register does exactly one of the following, listed
//   from highest to lowest priority:
//     rst    : load the NOP image and clear the counters and ctrl_err
//     stall  : hold the current contents (stall_cnt increments)
//     bubble : load the NOP image (bubble_cnt increments)
//     load   : capture the d_* fields, or the NOP image when d_valid=0
//   If stall and bubble are asserted together, the edge is treated as a
//   stall, and the sticky ctrl_err flag is set until the next rst.
//   Both event counters saturate at all-ones. clr_cnt zeroes the counters
//   synchronously but leaves ctrl_err alone.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   stall, bubble        pipeline control from the hazard unit
//   clr_cnt              synchronous clear of stall_cnt / bubble_cnt
//   d_*                  decode-stage slot (valid, stat, codes, operands, IDs)
//   E_*                  registered execute-stage slot
//   stall_cnt            cycles spent stalled (saturating)
//   bubble_cnt           bubbles injected (saturating)
//   ctrl_err             sticky flag: stall and bubble seen together
// -----------------------------------------------------------------------------
module pipe_exec_reg #(
    parameter int                 WORD_W    = 64,
    parameter int                 RID_W     = 4,
    parameter int                 CODE_W    = 4,
    parameter int                 STAT_W    = 3,
    parameter logic [CODE_W-1:0]  NOP_ICODE = 4'h1,
    parameter logic [RID_W-1:0]   RNONE     = 4'hF,
    parameter logic [STAT_W-1:0]  STAT_BUB  = 3'd0,
    parameter int                 CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic              clr_cnt,
    input  logic              d_valid,
    input  logic [STAT_W-1:0] d_stat,
    input  logic [CODE_W-1:0] d_icode,
    input  logic [CODE_W-1:0] d_ifun,
    input  logic [WORD_W-1:0] d_valC,
    input  logic [WORD_W-1:0] d_valA,
    input  logic [WORD_W-1:0] d_valB,
    input  logic [RID_W-1:0]  d_dstE,
    input  logic [RID_W-1:0]  d_dstM,
    input  logic [RID_W-1:0]  d_srcA,
    input  logic [RID_W-1:0]  d_srcB,
    output logic              E_valid,
    output logic [STAT_W-1:0] E_stat,
    output logic [CODE_W-1:0] E_icode,
    output logic [CODE_W-1:0] E_ifun,
    output logic [WORD_W-1:0] E_valC,
    output logic [WORD_W-1:0] E_valA,
    output logic [WORD_W-1:0] E_valB,
    output logic [RID_W-1:0]  E_dstE,
    output logic [RID_W-1:0]  E_dstM,
    output logic [RID_W-1:0]  E_srcA,
    output logic [RID_W-1:0]  E_srcB,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              ctrl_err
);

    // One pipeline slot, kept as a single packed word so that hold, NOP and
    // load are whole-slot moves.
    typedef struct packed {
        logic              valid;
        logic [STAT_W-1:0] stat;
        logic [CODE_W-1:0] icode;
        logic [CODE_W-1:0] ifun;
        logic [WORD_W-1:0] valC;
        logic [WORD_W-1:0] valA;
        logic [WORD_W-1:0] valB;
        logic [RID_W-1:0]  dstE;
        logic [RID_W-1:0]  dstM;
        logic [RID_W-1:0]  srcA;
        logic [RID_W-1:0]  srcB;
    } slot_t;

    // Image loaded on reset, on a bubble, and for an invalid decode slot.
    function automatic slot_t nop_slot();
        slot_t s;
        s.valid = 1'b0;
        s.stat  = STAT_BUB;
        s.icode = NOP_ICODE;
        s.ifun  = {CODE_W{1'b0}};
        s.valC  = {WORD_W{1'b0}};
        s.valA  = {WORD_W{1'b0}};
        s.valB  = {WORD_W{1'b0}};
        s.dstE  = RNONE;
        s.dstM  = RNONE;
        s.srcA  = RNONE;
        s.srcB  = RNONE;
        return s;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    slot_t             slot_r;
    slot_t             d_slot_s;
    slot_t             slot_nxt_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_nxt_s;
    logic [CNT_W-1:0]  bubble_cnt_nxt_s;
    logic              ctrl_err_r;
    logic              ctrl_err_nxt_s;

    assign d_slot_s = {d_valid, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
                       d_dstE, d_dstM, d_srcA, d_srcB};

    // Next slot contents: stall beats bubble; an invalid slot loads as a NOP.
    always_comb begin
        slot_nxt_s = slot_r;
        if (stall) begin
            slot_nxt_s = slot_r;
        end else if (bubble || !d_valid) begin
            slot_nxt_s = nop_slot();
        end else begin
            slot_nxt_s = d_slot_s;
        end
    end

    // Next counter and error values. A bubble that coincides with a stall is
    // not counted as a bubble, and clr_cnt overrides any increment.
    always_comb begin
        stall_cnt_nxt_s  = stall_cnt_r;
        bubble_cnt_nxt_s = bubble_cnt_r;
        if (clr_cnt) begin
            stall_cnt_nxt_s  = {CNT_W{1'b0}};
            bubble_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            if (stall) begin
                stall_cnt_nxt_s = sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_nxt_s = stall_cnt_r;
            end
            if (bubble && !stall) begin
                bubble_cnt_nxt_s = sat_inc(bubble_cnt_r);
            end else begin
                bubble_cnt_nxt_s = bubble_cnt_r;
            end
        end
        ctrl_err_nxt_s = ctrl_err_r | (stall & bubble);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r       <= nop_slot();
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
            ctrl_err_r   <= 1'b0;
        end else begin
            slot_r       <= slot_nxt_s;
            stall_cnt_r  <= stall_cnt_nxt_s;
            bubble_cnt_r <= bubble_cnt_nxt_s;
            ctrl_err_r   <= ctrl_err_nxt_s;
        end
    end

    assign E_valid    = slot_r.valid;
    assign E_stat     = slot_r.stat;
    assign E_icode    = slot_r.icode;
    assign E_ifun     = slot_r.ifun;
    assign E_valC     = slot_r.valC;
    assign E_valA     = slot_r.valA;
    assign E_valB     = slot_r.valB;
    assign E_dstE     = slot_r.dstE;
    assign E_dstM     = slot_r.dstM;
    assign E_srcA     = slot_r.srcA;
    assign E_srcB     = slot_r.srcB;
    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
    assign ctrl_err   = ctrl_err_r;

endmodule

// File: tb/tb_pipe_exec_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_exec_reg
//   Self-checking bench for pipe_exec_reg, built with CNT_W=4 so that counter
//   saturation can be reached quickly. The bench runs directed scenarios first
//   and then randomized control and data. After every edge it compares all
//   outputs with a slot-level reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_pipe_exec_reg;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } slot_t;

    logic clk = 1'b0;
    logic rst, stall, bubble, clr_cnt;
    slot_t din;
    slot_t dout;

    logic              E_valid;
    logic [2:0]        E_stat;
    logic [3:0]        E_icode, E_ifun;
    logic [63:0]       E_valC, E_valA, E_valB;
    logic [3:0]        E_dstE, E_dstM, E_srcA, E_srcB;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
    logic              ctrl_err;

    // Reference state.
    slot_t m_slot;
    int    m_sc, m_bc;
    logic  m_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_exec_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .clr_cnt(clr_cnt),
        .d_valid(din.valid), .d_stat(din.stat), .d_icode(din.icode), .d_ifun(din.ifun),
        .d_valC(din.valC), .d_valA(din.valA), .d_valB(din.valB),
        .d_dstE(din.dstE), .d_dstM(din.dstM), .d_srcA(din.srcA), .d_srcB(din.srcB),
        .E_valid(E_valid), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctrl_err(ctrl_err)
    );

    assign dout = {E_valid, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
                   E_dstE, E_dstM, E_srcA, E_srcB};

    function automatic slot_t nop();
        slot_t s;
        s = '0;
        s.icode = 4'h1;
        s.dstE = 4'hF; s.dstM = 4'hF; s.srcA = 4'hF; s.srcB = 4'hF;
        return s;
    endfunction

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one edge to the reference model using the inputs present at it.
    task automatic model_edge();
        if (rst) begin
            m_slot = nop(); m_sc = 0; m_bc = 0; m_err = 1'b0;
        end else begin
            if (stall && bubble) m_err = 1'b1;
            if (!stall) m_slot = (bubble || !din.valid) ? nop() : din;
            if (clr_cnt) begin
                m_sc = 0; m_bc = 0;
            end else begin
                if (stall) m_sc = sat(m_sc + 1);
                if (bubble && !stall) m_bc = sat(m_bc + 1);
            end
        end
    endtask

    // One clock edge, then compare every output with the model.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("slot", dout, m_slot);
        chk("stall_cnt", stall_cnt, m_sc);
        chk("bubble_cnt", bubble_cnt, m_bc);
        chk("ctrl_err", ctrl_err, m_err);
    endtask

    task automatic rand_din();
        din.valid = ($urandom_range(3, 0) != 0);
        din.stat  = 3'($urandom);
        din.icode = 4'($urandom);
        din.ifun  = 4'($urandom);
        din.valC  = {$urandom, $urandom};
        din.valA  = {$urandom, $urandom};
        din.valB  = {$urandom, $urandom};
        din.dstE  = 4'($urandom);
        din.dstM  = 4'($urandom);
        din.srcA  = 4'($urandom);
        din.srcB  = 4'($urandom);
    endtask

    initial begin
        m_slot = nop(); m_sc = 0; m_bc = 0; m_err = 1'b0;
        stall = 1'b0; bubble = 1'b0; clr_cnt = 1'b0;

        // Reset for two cycles with random data on the decode side.
        rst = 1'b1;
        rand_din();
        tick();
        rand_din();
        tick();
        chk("rst_icode", E_icode, 4'h1);
        chk("rst_dstE", E_dstE, 4'hF);
        chk("rst_srcB", E_srcB, 4'hF);
        chk("rst_valid", E_valid, 1'b0);

        // First load after reset.
        rst = 1'b0;
        din = '0;
        din.valid = 1'b1; din.icode = 4'd6; din.ifun = 4'd0;
        din.valA = 64'h5; din.valB = 64'h7;
        din.dstE = 4'd2; din.dstM = 4'hF; din.srcA = 4'd1; din.srcB = 4'd2;
        tick();
        chk("ld_icode", E_icode, 4'd6);
        chk("ld_valA", E_valA, 64'h5);
        chk("ld_valB", E_valB, 64'h7);
        chk("ld_dstE", E_dstE, 4'd2);
        chk("ld_valid", E_valid, 1'b1);

        // Stall for three cycles while the decode operand changes.
        stall = 1'b1;
        din.valA = 64'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valA", E_valA, 64'h5);
        end
        chk("stall_cnt3", stall_cnt, 4'd3);
        stall = 1'b0;
        tick();
        chk("unstall_valA", E_valA, 64'hFF);

        // Bubble with a valid instruction on the decode side.
        bubble = 1'b1;
        din.icode = 4'd5; din.dstM = 4'd3; din.stat = 3'd1;
        tick();
        chk("bub_icode", E_icode, 4'h1);
        chk("bub_dstM", E_dstM, 4'hF);
        chk("bub_stat", E_stat, 3'd0);
        chk("bub_valid", E_valid, 1'b0);
        chk("bub_cnt1", bubble_cnt, 4'd1);
        bubble = 1'b0;
        tick();

        // Stall and bubble together: hold, count as a stall, set ctrl_err.
        stall = 1'b1; bubble = 1'b1;
        din.icode = 4'd2;
        tick();
        chk("conf_icode", E_icode, 4'd5);
        chk("conf_err", ctrl_err, 1'b1);
        chk("conf_scnt", stall_cnt, 4'd4);
        chk("conf_bcnt", bubble_cnt, 4'd1);
        stall = 1'b0; bubble = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_din();
            tick();
            chk("err_sticky", ctrl_err, 1'b1);
        end

        // Saturation, then clear together with a stall.
        stall = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_scnt", stall_cnt, 4'd15);
        clr_cnt = 1'b1;
        tick();
        chk("clr_scnt", stall_cnt, 4'd0);
        chk("clr_err", ctrl_err, 1'b1);
        clr_cnt = 1'b0; stall = 1'b0;

        // Invalid decode slot loads the NOP image.
        rand_din();
        din.valid = 1'b0; din.icode = 4'd3;
        tick();
        chk("inv_slot", dout, nop());

        // Reset during a stall.
        stall = 1'b1; bubble = 1'b1; rst = 1'b1;
        tick();
        chk("mrst_slot", dout, nop());
        chk("mrst_scnt", stall_cnt, 4'd0);
        chk("mrst_err", ctrl_err, 1'b0);
        rst = 1'b0; stall = 1'b0; bubble = 1'b0;

        // Randomized control and data.
        for (int i = 0; i < 400; i++) begin
            rand_din();
            rst     = ($urandom_range(39, 0) == 0);
            stall   = ($urandom_range(3, 0) == 0);
            bubble  = ($urandom_range(4, 0) == 0);
            clr_cnt = ($urandom_range(15, 0) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
